// File: rtl/req_gnt_mon_pkg.sv
// Shared types, limits and helpers for the request/grant latency monitor.
package req_gnt_mon_pkg;

    // Property flavour: implication (vacuous when idle) or strict sequence.
    typedef enum logic {
        MODE_IMPL = 1'b0,
        MODE_SEQ  = 1'b1
    } mode_e;

    localparam int unsigned NCH_LIMIT     = 32;
    localparam int unsigned MAX_LAT_LIMIT = 15;
    localparam int unsigned SAT_W         = 32;
    // Per-channel, per-edge event count width (up to 15 passes or 2 fails).
    localparam int unsigned EV_W          = 5;

    // Per-channel resolution summary for one clock edge.
    typedef struct packed {
        logic [EV_W-1:0] pass_n;
        logic [EV_W-1:0] fail_n;
        logic            vac;
    } chan_ev_t;

    // Add b to a, clamping at the all-ones value of a w-bit counter.
    function automatic logic [SAT_W-1:0] sat_add(
        input logic [SAT_W-1:0] a,
        input logic [SAT_W-1:0] b,
        input int unsigned      w
    );
        logic [SAT_W:0] sum;
        logic [SAT_W:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = ((SAT_W + 1)'(1) << w) - (SAT_W + 1)'(1);
        if (sum > lim) begin
            return lim[SAT_W-1:0];
        end
        return sum[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/req_gnt_chan.sv
// Single-channel attempt tracker: one bit per in-flight attempt age.
module req_gnt_chan
    import req_gnt_mon_pkg::*;
#(
    parameter int unsigned MIN_LAT = 2,
    parameter int unsigned MAX_LAT = 2,
    parameter mode_e       MODE    = MODE_IMPL
) (
    input  logic     pclk,
    input  logic     prst,
    input  logic     en,
    input  logic     preq,
    input  logic     pgnt,
    output chan_ev_t ev_c
);

    // age_q[j] holds an attempt that was age j at the previous edge.
    logic [MAX_LAT-1:0] age_q;
    logic [MAX_LAT-1:0] age_d;
    // Full age view at the current edge, bit 0 being a fresh start.
    logic [MAX_LAT:0]   age_c;
    logic               start_c;

    // Current-edge age vector including any attempt starting now.
    always_comb begin
        start_c = en & preq;
        age_c   = {age_q, start_c};
    end

    // Resolve attempts in window, expire the oldest, carry survivors.
    always_comb begin
        ev_c  = '0;
        age_d = '0;
        for (int unsigned k = 0; k <= MAX_LAT; k++) begin
            if (k >= MIN_LAT && age_c[k] && pgnt) begin
                ev_c.pass_n = ev_c.pass_n + EV_W'(1);
            end else if (k == MAX_LAT && age_c[k]) begin
                ev_c.fail_n = ev_c.fail_n + EV_W'(1);
            end else if (k < MAX_LAT) begin
                age_d[k] = age_c[k];
            end
        end
        if (en && !preq) begin
            if (MODE == MODE_SEQ) begin
                ev_c.fail_n = ev_c.fail_n + EV_W'(1);
            end else begin
                ev_c.vac = 1'b1;
            end
        end
    end

    // Age shift register; reset discards every pending attempt.
    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end

endmodule

// File: rtl/req_gnt_monitor.sv
// Multi-channel request/grant latency monitor with pulses, counters and error capture.
module req_gnt_monitor
    import req_gnt_mon_pkg::*;
#(
    parameter int unsigned NCH     = 4,
    parameter int unsigned MIN_LAT = 2,
    parameter int unsigned MAX_LAT = 2,
    parameter mode_e       MODE    = MODE_IMPL,
    parameter int unsigned CNT_W   = 16,
    localparam int unsigned CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             pclk,
    input  logic             prst,
    input  logic             en,
    input  logic             clr,
    input  logic [NCH-1:0]   preq,
    input  logic [NCH-1:0]   pgnt,
    output logic [NCH-1:0]   pass,
    output logic [NCH-1:0]   fail,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] vac_cnt,
    output logic             err_sticky,
    output logic [CH_W-1:0]  first_fail_ch
);

    // Wide enough for NCH * 15 passes in one edge.
    localparam int unsigned SUM_W = 10;

    // Reject illegal configurations at elaboration.
    if (NCH == 0 || NCH > NCH_LIMIT || MIN_LAT == 0 || MIN_LAT > MAX_LAT ||
        MAX_LAT > MAX_LAT_LIMIT || CNT_W == 0 || CNT_W > SAT_W) begin : g_bad_param
        $fatal(1, "req_gnt_monitor: illegal parameters (need 1<=NCH<=32, 1<=MIN_LAT<=MAX_LAT<=15, 1<=CNT_W<=32)");
    end

    chan_ev_t         ev_c [NCH];
    logic [NCH-1:0]   pass_hit_c;
    logic [NCH-1:0]   fail_hit_c;
    logic [SUM_W-1:0] pass_sum_c;
    logic [SUM_W-1:0] fail_sum_c;
    logic [SUM_W-1:0] vac_sum_c;
    logic [CH_W-1:0]  ffc_c;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        req_gnt_chan #(
            .MIN_LAT (MIN_LAT),
            .MAX_LAT (MAX_LAT),
            .MODE    (MODE)
        ) u_chan (
            .pclk (pclk),
            .prst (prst),
            .en   (en),
            .preq (preq[i]),
            .pgnt (pgnt[i]),
            .ev_c (ev_c[i])
        );
    end

    // Fold per-channel events into hit masks, edge totals and lowest failing channel.
    always_comb begin
        pass_hit_c = '0;
        fail_hit_c = '0;
        pass_sum_c = '0;
        fail_sum_c = '0;
        vac_sum_c  = '0;
        ffc_c      = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            pass_hit_c[i] = (ev_c[i].pass_n != '0);
            fail_hit_c[i] = (ev_c[i].fail_n != '0);
            pass_sum_c    = pass_sum_c + SUM_W'(ev_c[i].pass_n);
            fail_sum_c    = fail_sum_c + SUM_W'(ev_c[i].fail_n);
            vac_sum_c     = vac_sum_c + SUM_W'(ev_c[i].vac);
            if (ev_c[i].fail_n != '0) begin
                ffc_c = CH_W'(i);
            end
        end
    end

    // One-cycle pass/fail pulses for the edge just decided.
    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            pass <= '0;
            fail <= '0;
        end else begin
            pass <= pass_hit_c;
            fail <= fail_hit_c;
        end
    end

    // Saturating event counters; clr drops this edge's contribution.
    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
            vac_cnt  <= '0;
        end else if (clr) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
            vac_cnt  <= '0;
        end else begin
            pass_cnt <= CNT_W'(sat_add(SAT_W'(pass_cnt), SAT_W'(pass_sum_c), CNT_W));
            fail_cnt <= CNT_W'(sat_add(SAT_W'(fail_cnt), SAT_W'(fail_sum_c), CNT_W));
            vac_cnt  <= CNT_W'(sat_add(SAT_W'(vac_cnt), SAT_W'(vac_sum_c), CNT_W));
        end
    end

    // Capture the first failure only; later failures leave the channel index alone.
    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            err_sticky    <= 1'b0;
            first_fail_ch <= '0;
        end else if (clr) begin
            err_sticky    <= 1'b0;
            first_fail_ch <= '0;
        end else if ((|fail_hit_c) && !err_sticky) begin
            err_sticky    <= 1'b1;
            first_fail_ch <= ffc_c;
        end
    end

endmodule

// File: tb/tb_req_gnt_monitor.sv
// Directed bench for req_gnt_monitor across four parameterisations sharing one stimulus.
module tb_req_gnt_monitor;
    import req_gnt_mon_pkg::*;

    logic       pclk;
    logic       prst;
    logic       en;
    logic       clr;
    logic [3:0] preq;
    logic [3:0] pgnt;

    // Defaults
    logic [3:0]  d_pass, d_fail;
    logic [15:0] d_pcnt, d_fcnt, d_vcnt;
    logic        d_err;
    logic [1:0]  d_ffc;
    // MIN_LAT=1, MAX_LAT=3
    logic [3:0]  l_pass, l_fail;
    logic [15:0] l_pcnt, l_fcnt, l_vcnt;
    logic        l_err;
    logic [1:0]  l_ffc;
    // MODE_SEQ
    logic [3:0]  s_pass, s_fail;
    logic [15:0] s_pcnt, s_fcnt, s_vcnt;
    logic        s_err;
    logic [1:0]  s_ffc;
    // CNT_W=4
    logic [3:0]  t_pass, t_fail;
    logic [3:0]  t_pcnt, t_fcnt, t_vcnt;
    logic        t_err;
    logic [1:0]  t_ffc;

    int n_chk;
    int n_pass;

    req_gnt_monitor u_def (
        .pclk(pclk), .prst(prst), .en(en), .clr(clr), .preq(preq), .pgnt(pgnt),
        .pass(d_pass), .fail(d_fail), .pass_cnt(d_pcnt), .fail_cnt(d_fcnt),
        .vac_cnt(d_vcnt), .err_sticky(d_err), .first_fail_ch(d_ffc)
    );

    req_gnt_monitor #(.MIN_LAT(1), .MAX_LAT(3)) u_lat (
        .pclk(pclk), .prst(prst), .en(en), .clr(clr), .preq(preq), .pgnt(pgnt),
        .pass(l_pass), .fail(l_fail), .pass_cnt(l_pcnt), .fail_cnt(l_fcnt),
        .vac_cnt(l_vcnt), .err_sticky(l_err), .first_fail_ch(l_ffc)
    );

    req_gnt_monitor #(.MODE(MODE_SEQ)) u_seq (
        .pclk(pclk), .prst(prst), .en(en), .clr(clr), .preq(preq), .pgnt(pgnt),
        .pass(s_pass), .fail(s_fail), .pass_cnt(s_pcnt), .fail_cnt(s_fcnt),
        .vac_cnt(s_vcnt), .err_sticky(s_err), .first_fail_ch(s_ffc)
    );

    req_gnt_monitor #(.CNT_W(4)) u_sat (
        .pclk(pclk), .prst(prst), .en(en), .clr(clr), .preq(preq), .pgnt(pgnt),
        .pass(t_pass), .fail(t_fail), .pass_cnt(t_pcnt), .fail_cnt(t_fcnt),
        .vac_cnt(t_vcnt), .err_sticky(t_err), .first_fail_ch(t_ffc)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic idle_inputs();
        en   = 1'b0;
        clr  = 1'b0;
        preq = 4'b0000;
        pgnt = 4'b0000;
    endtask

    task automatic do_reset();
        idle_inputs();
        prst = 1'b1;
        tick();
        tick();
        prst = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        do_reset();

        // Reset state
        check("rst_pass",     32'(d_pass), 32'd0);
        check("rst_fail",     32'(d_fail), 32'd0);
        check("rst_pass_cnt", 32'(d_pcnt), 32'd0);
        check("rst_fail_cnt", 32'(d_fcnt), 32'd0);
        check("rst_vac_cnt",  32'(d_vcnt), 32'd0);
        check("rst_err",      32'(d_err),  32'd0);
        check("rst_ffc",      32'(d_ffc),  32'd0);

        // ch0: request, grant two edges later -> pass
        en = 1'b1; preq = 4'b0001;
        tick();
        check("t1_vac_cnt", 32'(d_vcnt), 32'd3);
        idle_inputs();
        tick();
        check("t1_pass_early", 32'(d_pass), 32'd0);
        pgnt = 4'b0001;
        tick();
        check("t1_pass_pulse", 32'(d_pass), 32'b0001);
        check("t1_pass_cnt",   32'(d_pcnt), 32'd1);
        check("t1_fail_cnt",   32'(d_fcnt), 32'd0);
        pgnt = 4'b0000;
        tick();
        check("t1_pass_width", 32'(d_pass), 32'd0);

        // ch1: request, grant one edge too late -> fail at age MAX_LAT
        en = 1'b1; preq = 4'b0010;
        tick();
        idle_inputs();
        tick();
        check("t2_err_before", 32'(d_err), 32'd0);
        tick();
        check("t2_fail_pulse", 32'(d_fail), 32'b0010);
        check("t2_fail_cnt",   32'(d_fcnt), 32'd1);
        check("t2_err",        32'(d_err),  32'd1);
        check("t2_ffc",        32'(d_ffc),  32'd1);
        pgnt = 4'b0010;
        tick();
        check("t2_late_gnt_pass", 32'(d_pass), 32'd0);
        check("t2_late_gnt_cnt",  32'(d_pcnt), 32'd1);
        check("t2_fail_width",    32'(d_fail), 32'd0);

        // Two overlapping attempts, one grant
        do_reset();
        en = 1'b1; preq = 4'b0001;
        tick();
        tick();
        check("t3_lat_pcnt_before", 32'(l_pcnt), 32'd0);
        idle_inputs();
        pgnt = 4'b0001;
        tick();
        check("t3_lat_pass_pulse", 32'(l_pass), 32'b0001);
        check("t3_lat_pass_cnt",   32'(l_pcnt), 32'd2);
        check("t3_def_pass_cnt",   32'(d_pcnt), 32'd1);
        pgnt = 4'b0000;
        tick();
        check("t3_def_fail_cnt", 32'(d_fcnt), 32'd1);
        check("t3_def_fail",     32'(d_fail), 32'b0001);
        check("t3_def_ffc",      32'(d_ffc),  32'd0);
        check("t3_lat_fail_cnt", 32'(l_fcnt), 32'd0);

        // Idle enabled edges: vacuous (IMPL) vs immediate failure (SEQ)
        do_reset();
        en = 1'b1; preq = 4'b0000;
        tick();
        check("t4_seq_fail_all", 32'(s_fail), 32'b1111);
        for (int i = 1; i < 8; i++) tick();
        idle_inputs();
        check("t4_impl_vac_cnt",  32'(d_vcnt), 32'd32);
        check("t4_impl_fail_cnt", 32'(d_fcnt), 32'd0);
        check("t4_seq_fail_cnt",  32'(s_fcnt), 32'd32);
        check("t4_seq_vac_cnt",   32'(s_vcnt), 32'd0);
        check("t4_seq_err",       32'(s_err),  32'd1);
        check("t4_seq_ffc",       32'(s_ffc),  32'd0);

        // 20 pipelined passing attempts, saturation at 15 for CNT_W=4
        do_reset();
        for (int i = 0; i < 20; i++) begin
            en = 1'b1; preq = 4'b0001; pgnt = 4'b0001;
            tick();
            if (i == 15) check("t5_sat_pcnt_e15", 32'(t_pcnt), 32'd14);
        end
        en = 1'b0; preq = 4'b0000;
        tick();
        tick();
        check("t5_def_pass_cnt", 32'(d_pcnt), 32'd20);
        check("t5_sat_pass_cnt", 32'(t_pcnt), 32'd15);
        check("t5_sat_vac_cnt",  32'(t_vcnt), 32'd15);
        check("t5_sat_fail_cnt", 32'(t_fcnt), 32'd0);
        // clr with an attempt still pending
        pgnt = 4'b0000; en = 1'b1; preq = 4'b0001;
        tick();
        idle_inputs();
        clr = 1'b1;
        tick();
        check("t5_clr_pass_cnt", 32'(t_pcnt), 32'd0);
        check("t5_clr_vac_cnt",  32'(t_vcnt), 32'd0);
        clr = 1'b0; pgnt = 4'b0001;
        tick();
        check("t5_post_clr_pass", 32'(t_pass), 32'b0001);
        check("t5_post_clr_cnt",  32'(t_pcnt), 32'd1);
        // clr coincident with a resolution wins
        pgnt = 4'b0000; en = 1'b1; preq = 4'b0001;
        tick();
        idle_inputs();
        tick();
        pgnt = 4'b0001; clr = 1'b1;
        tick();
        check("t5_clr_wins_cnt", 32'(t_pcnt), 32'd0);
        idle_inputs();

        // Mid-cycle reset discards a pending attempt
        en = 1'b1; preq = 4'b0100;
        tick();
        idle_inputs();
        tick();
        #3;
        prst = 1'b1;
        #1;
        check("t6_async_def_pcnt", 32'(d_pcnt), 32'd0);
        check("t6_async_def_vcnt", 32'(d_vcnt), 32'd0);
        check("t6_async_seq_err",  32'(s_err),  32'd0);
        check("t6_async_seq_fcnt", 32'(s_fcnt), 32'd0);
        check("t6_async_sat_pass", 32'(t_pass), 32'd0);
        tick();
        prst = 1'b0;
        tick();
        check("t6_lat_fail",      32'(l_fail), 32'd0);
        check("t6_lat_fail_cnt",  32'(l_fcnt), 32'd0);
        tick();
        check("t6_lat_fail_cnt2", 32'(l_fcnt), 32'd0);
        check("t6_def_fail_cnt",  32'(d_fcnt), 32'd0);
        check("t6_lat_err",       32'(l_err),  32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/req_gnt_monitor.md
REQ_GNT_MONITOR -- requirements
Module: req_gnt_monitor

Interface
REQ-001 Parameter NCH, 4, number of independent request/grant channels (1..32).
REQ-002 Parameter MIN_LAT, 2, earliest grant cycle after request (1..MAX_LAT).
REQ-003 Parameter MAX_LAT, 2, latest grant cycle after request (MIN_LAT..15).
REQ-004 Parameter MODE, MODE_IMPL, MODE_IMPL (preq implies grant window) or MODE_SEQ (every enabled cycle must start with preq).
REQ-005 Parameter CNT_W, 16, width of the event counters.
REQ-006 pclk  input  1  single clock; all sampling on rising edge.
REQ-007 prst  input  1  reset, asynchronous and active-high.
REQ-008 en  input  1  when high, new attempts start; when low, no new attempts start.
REQ-009 clr  input  1  synchronous clear of counters and error capture.
REQ-010 preq  input  NCH  per-channel request.
REQ-011 pgnt  input  NCH  per-channel grant.
REQ-012 pass  output  NCH  one-cycle pulse: at least one attempt on that channel passed.
REQ-013 fail  output  NCH  one-cycle pulse: at least one attempt on that channel failed.
REQ-014 pass_cnt, fail_cnt, vac_cnt  output  CNT_W each  saturating event counts.
REQ-015 err_sticky  output  1  set on first failure; held until clr or reset.
REQ-016 first_fail_ch  output  max(1,clog2(NCH))  lowest-index channel of the first failing edge.

Function
REQ-017 An attempt on channel i SHALL start at every rising edge where en=1 and preq[i]=1; overlapping attempts SHALL be tracked independently, one per start cycle.
REQ-018 An attempt of age k (edges since start) SHALL pass at the first edge with MIN_LAT<=k<=MAX_LAT and pgnt[i]=1, then retire.
REQ-019 An attempt reaching age MAX_LAT with pgnt[i]=0 SHALL fail and retire.
REQ-020 One grant edge SHALL pass every pending attempt of that channel inside its window.
REQ-021 Grants outside any attempt window SHALL be ignored.
REQ-022 MODE_IMPL: an enabled edge with preq[i]=0 SHALL count once in vac_cnt per channel; no pass/fail.
REQ-023 MODE_SEQ: an enabled edge with preq[i]=0 SHALL be an immediate failure for channel i; vac_cnt SHALL stay 0.
REQ-024 pass/fail pulses SHALL be registered, asserted the cycle after the deciding edge, one cycle wide.
REQ-025 pass_cnt and fail_cnt SHALL add the number of attempts resolved at that edge summed over all channels, saturating at 2^CNT_W-1.
REQ-026 err_sticky and first_fail_ch SHALL update in the same cycle as the fail pulse; later failures SHALL not change first_fail_ch.
REQ-027 en=0 SHALL not cancel pending attempts; they resolve normally.
REQ-028 clr SHALL zero counters, err_sticky and first_fail_ch next cycle without affecting pending attempts; clr coincident with a resolution SHALL win (counts from that edge dropped).
REQ-029 An attempt resolving on the same edge a new attempt starts SHALL be handled independently.

Reset
REQ-030 prst SHALL asynchronously clear all pending attempts, pass=0, fail=0, all counters=0, err_sticky=0, first_fail_ch=0.
REQ-031 Attempts pending at reset SHALL be discarded with no pass/fail reported; tracking restarts at the first edge after prst deasserts.

Structure
REQ-032 Package req_gnt_mon_pkg SHALL hold the mode enum (MODE_IMPL, MODE_SEQ) and the counter saturating-add function.
REQ-033 Per-channel tracking SHALL be in sub-module req_gnt_chan: age shift register of MAX_LAT+1 bits, outputs per-edge pass count, fail count, vacuous flag.
REQ-034 Parameter legality (MIN_LAT<=MAX_LAT<=15, NCH>=1) SHALL be checked at elaboration with a fatal message.

Verification
REQ-035 Defaults, ch0: preq at edge 10, pgnt at edge 12 -> pass[0] pulse after edge 12, pass_cnt=1, fail_cnt=0.
REQ-036 Defaults, ch1: preq at edge 10, pgnt at edge 13 only -> fail[1] after edge 12, err_sticky=1, first_fail_ch=1.
REQ-037 MIN_LAT=1, MAX_LAT=3: preq at edges 5 and 6, single pgnt at edge 7 -> pass_cnt=2 after one pulse.
REQ-038 MODE_IMPL, en=1, no preq for 8 edges on NCH=4 -> vac_cnt=32; MODE_SEQ same stimulus -> fail_cnt=32, first_fail_ch=0.
REQ-039 CNT_W=4: 20 passing attempts -> pass_cnt saturates at 15; then clr -> 0 with a pending attempt still passing to 1.
REQ-040 preq at edge 3, prst asserted mid-cycle before edge 5 -> all outputs 0 immediately, no fail after deassertion.
